// File: rtl/vga_scan_engine_if.sv
// Display-path bundle: frame-buffer read port plus the video pins.
// The engine drives it through the master modport, a frame buffer/monitor uses the slave side.
interface vga_scan_engine_if #(
    parameter int COLOR_W = 4,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 9
);
    logic [3*COLOR_W-1:0] ram_pixel;
    logic [ROW_W-1:0]     row_read;
    logic [COL_W-1:0]     col_read;
    logic                 vga_hs;
    logic                 vga_vs;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;
    logic                 h_active;
    logic                 v_active;
    logic                 line_start;
    logic                 frame_start;

    modport master (
        input  ram_pixel,
        output row_read, col_read,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b,
        output h_active, v_active, line_start, frame_start
    );

    modport slave (
        output ram_pixel,
        input  row_read, col_read,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b,
        input  h_active, v_active, line_start, frame_start
    );
endinterface

// File: rtl/vga_scan_engine.sv
// VGA scan engine: pixel/line counters, window addressing into the frame buffer,
// and a two-stage pipeline that keeps syncs, active flags and colour aligned.
module vga_scan_engine #(
    parameter int                   CLK_DIV  = 4,
    parameter int                   H_ACTIVE = 640,
    parameter int                   H_FP     = 16,
    parameter int                   H_SYNC   = 96,
    parameter int                   H_BP     = 48,
    parameter int                   V_ACTIVE = 480,
    parameter int                   V_FP     = 10,
    parameter int                   V_SYNC   = 2,
    parameter int                   V_BP     = 29,
    parameter logic                 HS_POL   = 1'b0,
    parameter logic                 VS_POL   = 1'b0,
    parameter int                   IMG_W    = 320,
    parameter int                   IMG_H    = 240,
    parameter int                   IMG_X    = 0,
    parameter int                   IMG_Y    = 0,
    parameter int                   SCALE    = 1,
    parameter int                   COLOR_W  = 4,
    parameter logic [3*COLOR_W-1:0] BORDER   = '0,
    parameter int                   ROW_W    = 8,
    parameter int                   COL_W    = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    vga_scan_engine_if.master     bus
);

    localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W      = $clog2(H_TOTAL_I);
    localparam int VC_W      = $clog2(V_TOTAL_I);
    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int PIX_W     = 3 * COLOR_W;

    localparam logic [31:0] H_TOTAL    = H_TOTAL_I;
    localparam logic [31:0] V_TOTAL    = V_TOTAL_I;
    localparam logic [31:0] H_ACT_END  = H_ACTIVE;
    localparam logic [31:0] V_ACT_END  = V_ACTIVE;
    localparam logic [31:0] H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam logic [31:0] V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam logic [31:0] H_SYNC_LEN = H_SYNC;
    localparam logic [31:0] V_SYNC_LEN = V_SYNC;
    localparam logic [31:0] WIN_X0     = IMG_X;
    localparam logic [31:0] WIN_Y0     = IMG_Y;
    localparam logic [31:0] WIN_W      = IMG_W * SCALE;
    localparam logic [31:0] WIN_H      = IMG_H * SCALE;

    logic [DIV_W-1:0] div_q, div_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic             pix_en;

    logic [31:0]      hc_x, vc_x, dx, dy;
    logic             win, h_act, v_act, h_sync, v_sync;

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             a_win_q, a_win_d;
    logic             a_hact_q, a_hact_d;
    logic             a_vact_q, a_vact_d;
    logic             a_hsync_q, a_hsync_d;
    logic             a_vsync_q, a_vsync_d;
    logic             a_hzero_q, a_hzero_d;
    logic             a_vzero_q, a_vzero_d;

    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             hact_q, hact_d;
    logic             vact_q, vact_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;

    assign pix_en = enable && (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (!enable) begin
            div_d = '0;
            hc_d  = '0;
            vc_d  = '0;
        end else begin
            div_d = pix_en ? '0 : div_q + DIV_W'(1);
            if (pix_en) begin
                if (hc_q == HC_W'(H_TOTAL - 1)) begin
                    hc_d = '0;
                    vc_d = (vc_q == VC_W'(V_TOTAL - 1)) ? '0 : vc_q + VC_W'(1);
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
        end
    end

    // Offsets wrap to huge values left of / above the origin, so one unsigned compare bounds each range.
    always_comb begin
        hc_x   = 32'(hc_q);
        vc_x   = 32'(vc_q);
        dx     = hc_x - WIN_X0;
        dy     = vc_x - WIN_Y0;
        h_act  = hc_x < H_ACT_END;
        v_act  = vc_x < V_ACT_END;
        h_sync = (hc_x - H_SYNC_BEG) < H_SYNC_LEN;
        v_sync = (vc_x - V_SYNC_BEG) < V_SYNC_LEN;
        win    = (dx < WIN_W) && (dy < WIN_H);
    end

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        a_win_d   = a_win_q;
        a_hact_d  = a_hact_q;
        a_vact_d  = a_vact_q;
        a_hsync_d = a_hsync_q;
        a_vsync_d = a_vsync_q;
        a_hzero_d = a_hzero_q;
        a_vzero_d = a_vzero_q;
        if (!enable) begin
            row_d     = '0;
            col_d     = '0;
            a_win_d   = 1'b0;
            a_hact_d  = 1'b0;
            a_vact_d  = 1'b0;
            a_hsync_d = 1'b0;
            a_vsync_d = 1'b0;
            a_hzero_d = 1'b0;
            a_vzero_d = 1'b0;
        end else if (pix_en) begin
            a_win_d   = win;
            a_hact_d  = h_act;
            a_vact_d  = v_act;
            a_hsync_d = h_sync;
            a_vsync_d = v_sync;
            a_hzero_d = (hc_q == '0);
            a_vzero_d = (vc_q == '0);
            if (win) begin
                col_d = COL_W'(dx >> (SCALE - 1));
                row_d = ROW_W'(dy >> (SCALE - 1));
            end
        end
    end

    // Strobes are only high in the single clk after the stage-B load that shows column 0.
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        hact_d  = hact_q;
        vact_d  = vact_q;
        rgb_d   = rgb_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (!enable) begin
            hs_d   = ~HS_POL;
            vs_d   = ~VS_POL;
            hact_d = 1'b0;
            vact_d = 1'b0;
            rgb_d  = '0;
        end else if (pix_en) begin
            hs_d    = a_hsync_q ? HS_POL : ~HS_POL;
            vs_d    = a_vsync_q ? VS_POL : ~VS_POL;
            hact_d  = a_hact_q;
            vact_d  = a_vact_q;
            rgb_d   = '0;
            if (a_hact_q && a_vact_q) begin
                rgb_d = a_win_q ? bus.ram_pixel : BORDER;
            end
            line_d  = a_hzero_q;
            frame_d = a_hzero_q && a_vzero_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            a_win_q   <= 1'b0;
            a_hact_q  <= 1'b0;
            a_vact_q  <= 1'b0;
            a_hsync_q <= 1'b0;
            a_vsync_q <= 1'b0;
            a_hzero_q <= 1'b0;
            a_vzero_q <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            hact_q    <= 1'b0;
            vact_q    <= 1'b0;
            rgb_q     <= '0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            row_q     <= row_d;
            col_q     <= col_d;
            a_win_q   <= a_win_d;
            a_hact_q  <= a_hact_d;
            a_vact_q  <= a_vact_d;
            a_hsync_q <= a_hsync_d;
            a_vsync_q <= a_vsync_d;
            a_hzero_q <= a_hzero_d;
            a_vzero_q <= a_vzero_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            hact_q    <= hact_d;
            vact_q    <= vact_d;
            rgb_q     <= rgb_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.row_read    = row_q;
    assign bus.col_read    = col_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_r       = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign bus.vga_g       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign bus.vga_b       = rgb_q[COLOR_W-1:0];
    assign bus.h_active    = hact_q;
    assign bus.v_active    = vact_q;
    assign bus.line_start  = line_q;
    assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Scoreboard bench for vga_scan_engine on a shrunken 24x12 raster with SCALE=2,
// an offset window that runs past the active area, and positive hsync polarity.
module tb_vga_scan_engine;

    localparam int D    = 3;
    localparam int HA   = 16;
    localparam int HF   = 2;
    localparam int HS   = 3;
    localparam int HB   = 3;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VA   = 8;
    localparam int VF   = 1;
    localparam int VS   = 2;
    localparam int VB   = 1;
    localparam int VT   = VA + VF + VS + VB;
    localparam int IW   = 6;
    localparam int IH   = 4;
    localparam int IX   = 2;
    localparam int IY   = 1;
    localparam int SC   = 2;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;
    localparam logic [11:0] BORDER_C = 12'h5A3;
    localparam int NPROBE = 14;

    typedef struct {
        int         n;
        int         x;
        int         y;
        logic       pix;
        logic       hs, vs, ha, va, ls, fs;
        logic [11:0] rgb;
        logic [2:0] row, col;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        ha, va, hs, vs;
    } probe_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_model = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    probe_t probes [NPROBE];

    vga_scan_engine_if #(.COLOR_W(4), .ROW_W(3), .COL_W(3)) bus ();

    vga_scan_engine #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HPOL), .VS_POL(VPOL),
        .IMG_W(IW), .IMG_H(IH), .IMG_X(IX), .IMG_Y(IY), .SCALE(SC),
        .COLOR_W(4), .BORDER(BORDER_C), .ROW_W(3), .COL_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pixel_of(input logic [2:0] r, input logic [2:0] c);
        return {1'b1, r, 1'b0, c, 4'hA};
    endfunction

    assign bus.ram_pixel = pixel_of(bus.row_read, bus.col_read);

    function automatic bit in_win(input int x, input int y);
        return (x >= IX) && (x < IX + IW * SC) && (y >= IY) && (y < IY + IH * SC);
    endfunction

    // Expected pins at the negedge following the n-th consecutive enabled edge (n=0: in reset).
    function automatic exp_t model(input int n);
        exp_t e;
        int   x;
        int   y;
        int   p;
        bit   found;
        e.n = n; e.x = -1; e.y = -1; e.pix = 1'b0;
        e.hs = ~HPOL; e.vs = ~VPOL; e.ha = 1'b0; e.va = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        e.rgb = '0; e.row = '0; e.col = '0;
        if (n >= D) begin
            found = 1'b0;
            for (int q = n / D - 1; q >= 0 && !found; q--) begin
                x = q % HT;
                y = (q / HT) % VT;
                if (in_win(x, y)) begin
                    found = 1'b1;
                    e.row = 3'((y - IY) / SC);
                    e.col = 3'((x - IX) / SC);
                end
            end
        end
        if (n >= 2 * D) begin
            p = n / D - 2;
            x = p % HT;
            y = (p / HT) % VT;
            e.pix = 1'b1; e.x = x; e.y = y;
            e.ha = (x < HA);
            e.va = (y < VA);
            e.hs = (x >= HA + HF && x < HA + HF + HS) ? HPOL : ~HPOL;
            e.vs = (y >= VA + VF && y < VA + VF + VS) ? VPOL : ~VPOL;
            if (e.ha && e.va)
                e.rgb = in_win(x, y) ? pixel_of(3'((y - IY) / SC), 3'((x - IX) / SC)) : BORDER_C;
            e.ls = (n % D == 0) && (x == 0);
            e.fs = e.ls && (y == 0);
        end
        return e;
    endfunction

    function automatic logic [23:0] actual_vec();
        return {bus.vga_hs, bus.vga_vs, bus.h_active, bus.v_active, bus.line_start,
                bus.frame_start, bus.vga_r, bus.vga_g, bus.vga_b, bus.row_read, bus.col_read};
    endfunction

    function automatic logic [23:0] exp_vec(input exp_t e);
        return {e.hs, e.vs, e.ha, e.va, e.ls, e.fs, e.rgb, e.row, e.col};
    endfunction

    task automatic check_output(input string name, input logic [23:0] got, input logic [23:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got {hs,vs,ha,va,ls,fs,rgb,row,col}=%b_%b_%b_%b_%b_%b_%h_%0d_%0d required %b_%b_%b_%b_%b_%b_%h_%0d_%0d",
                     name, got[23], got[22], got[21], got[20], got[19], got[18], got[17:6], got[5:3], got[2:0],
                     req[23], req[22], req[21], req[20], req[19], req[18], req[17:6], req[5:3], req[2:0]);
        end
    endtask

    // Drive one cycle's inputs and queue the pins expected at the following negedge.
    task automatic apply_stimulus(input logic r, input logic en);
        @(negedge clk);
        #1;
        rst = r;
        enable = en;
        if (r || !en) n_model = 0;
        else n_model++;
        sb_q.push_back(model(n_model));
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #1;
        rst = 1'b1;
        n_model = 0;
        #1;
        check_output("async_reset", actual_vec(), exp_vec(model(0)));
        sb_q.push_back(model(0));
    endtask

    initial begin
        probes[0]  = '{0,  0,  12'h5A3, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[1]  = '{2,  1,  12'h80A, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[2]  = '{3,  2,  12'h80A, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[3]  = '{4,  3,  12'h91A, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[4]  = '{13, 7,  12'hB5A, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[5]  = '{13, 8,  12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
        probes[6]  = '{14, 1,  12'h5A3, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[7]  = '{1,  4,  12'h5A3, 1'b1, 1'b1, 1'b0, 1'b1};
        probes[8]  = '{16, 1,  12'h000, 1'b0, 1'b1, 1'b0, 1'b1};
        probes[9]  = '{18, 0,  12'h000, 1'b0, 1'b1, 1'b1, 1'b1};
        probes[10] = '{20, 0,  12'h000, 1'b0, 1'b1, 1'b1, 1'b1};
        probes[11] = '{21, 0,  12'h000, 1'b0, 1'b1, 1'b0, 1'b1};
        probes[12] = '{5,  9,  12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        probes[13] = '{0,  11, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
    end

    // Monitor: the DUT presents a fresh set of pins every clk; pop and compare each one.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_output($sformatf("scan n=%0d px(%0d,%0d)", mon_e.n, mon_e.x, mon_e.y),
                         actual_vec(), exp_vec(mon_e));
            if (mon_e.pix && (mon_e.n % D == 0)) begin
                for (int i = 0; i < NPROBE; i++) begin
                    if (probes[i].x == mon_e.x && probes[i].y == mon_e.y) begin
                        check_output($sformatf("probe(%0d,%0d)", probes[i].x, probes[i].y),
                                     {bus.vga_hs, bus.vga_vs, bus.h_active, bus.v_active, 2'b00,
                                      bus.vga_r, bus.vga_g, bus.vga_b, 6'd0},
                                     {probes[i].hs, probes[i].vs, probes[i].ha, probes[i].va, 2'b00,
                                      probes[i].rgb, 6'd0});
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        repeat (4) apply_stimulus(1'b1, 1'b0);
        repeat (2 * HT * VT * D + 400) apply_stimulus(1'b0, 1'b1);
        repeat (10) apply_stimulus(1'b0, 1'b0);
        repeat (166) apply_stimulus(1'b0, 1'b1);
        async_reset_check();
        repeat (3) apply_stimulus(1'b1, 1'b1);
        repeat (HT * VT * D + 20) apply_stimulus(1'b0, 1'b1);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL drain: got %0d queued entries, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine generating sync, blanking, image-window addressing and pixel colour output for the accelerator display path. It advances pixel and line counters on an internal pixel-clock enable derived from `clk`. It issues row/column read addresses to the frame buffer and returns buffer pixels, blanking or a border colour. Sync, active-video and colour are delay-matched.

## Interface
- `CLK_DIV`, 4: `clk` cycles per pixel; legal range 2..16.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48. Horizontal segments in pixels, in that order; H_TOTAL = sum = 800.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 29. Vertical segments in lines; V_TOTAL = 521.
- `HS_POL`, `VS_POL`: 0, 0. Asserted sync level.
- `IMG_W`, `IMG_H`: 320, 240. Image size in buffer pixels.
- `IMG_X`, `IMG_Y`: 0, 0. Window origin in active-area coordinates.
- `SCALE`: 1. Must be 1 or 2; each buffer pixel covers SCALE×SCALE screen pixels.
- `COLOR_W`: 4. Bits per colour channel.
- `BORDER`: 0. Colour shown for active pixels outside the window; 3·COLOR_W bits, packed {r,g,b}.
- `ROW_W`, `COL_W`: 8, 9. Address widths.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `enable`  in  1  scan enable; 0 holds the engine in reset state (synchronous).
- `ram_pixel`  in  3·COLOR_W  buffer data {r,g,b}; valid within CLK_DIV−1 clk cycles of an address change.
- `row_read`  out  ROW_W  buffer row address.
- `col_read`  out  COL_W  buffer column address.
- `vga_hs`, `vga_vs`  out  1  syncs.
- `vga_r`, `vga_g`, `vga_b`  out  COLOR_W  colour.
- `h_active`, `v_active`  out  1  active-video flags, delay-matched to colour.
- `line_start`, `frame_start`  out  1  one-`clk` strobes.

## Operation
- Divider: `div` counts 0..CLK_DIV−1 and wraps. `pix_en` is high when `div` = CLK_DIV−1.
- Counters advance on `pix_en`:
  - `hc` counts 0..H_TOTAL−1. On wrap, `hc`←0 and `vc` increments.
  - `vc` counts 0..V_TOTAL−1 and wraps to 0.
- Region decode from `hc`/`vc`:
  - Active when hc < H_ACTIVE (resp. vc < V_ACTIVE).
  - Sync when H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC; vertical decode is the same form.
- Window `win` is true when both hold:
  - IMG_X ≤ hc < IMG_X+IMG_W·SCALE
  - IMG_Y ≤ vc < IMG_Y+IMG_H·SCALE
- Stage A, on `pix_en`, registers:
  - `col_read` = (hc−IMG_X)>>(SCALE−1) and `row_read` = (vc−IMG_Y)>>(SCALE−1), truncated to width, only when `win`; otherwise addresses hold their last value.
  - `win`, both active flags, and both sync decodes.
- Stage B, on the next `pix_en`, registers all outputs from stage A:
  - Colour = `ram_pixel` if win; BORDER if both active flags are set and not win; 0 otherwise.
  - Blanking always forces 0.
  - vga_hs = HS_POL when in sync, else ~HS_POL. vga_vs follows the same rule.
- Strobes: `line_start` is high for the `clk` cycle following the stage-B update that presents hc = 0. `frame_start` is the same but requires hc = 0 and vc = 0.
- Reset / `enable`=0, with `rst` asynchronous and `enable`=0 synchronous:
  - div, hc, vc and addresses go to 0.
  - Colour, strobes and active flags go to 0.
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL.
  - The scan restarts at hc = vc = 0 on the first cycle with `rst`=0 and `enable`=1.

## Timing
- Output latency is 2 pixel periods (2·CLK_DIV clk) from counter value to pins. Syncs, flags and colour are aligned to each other.
- The first `pix_en` after release occurs CLK_DIV−1 cycles after the first enabled cycle. Stage-B outputs remain at reset values until the second `pix_en`.
- The buffer has CLK_DIV−1 clk cycles to return data. `ram_pixel` is sampled on the `pix_en` after the address update.
- Line period is H_TOTAL·CLK_DIV clk (3200 with defaults). Frame period is V_TOTAL line periods.
- Horizontal wrap and line increment occur on the same `pix_en`. On a simultaneous `vc` wrap, `frame_start` and `line_start` pulse on the same clk.
- Window extending past the active area: pixels outside the active area are blank, and their addresses are still issued.

## Test plan
- Reset: assert `rst` mid-line → all outputs at reset values immediately, without waiting for `clk`. Release → `frame_start` occurs 2·CLK_DIV clk after the first enabled cycle.
- Default sync timing:
  - `vga_hs` low for 384 clk with period 3200 clk.
  - `vga_vs` low for 6400 clk with period 1,667,200 clk.
  - `h_active` high 2560 clk per line.
- Window, SCALE=1, default buffer returning {row,col}-derived data:
  - Screen (0,0) → address (0,0), colour of pixel 0.
  - (319,239) → address (239,319).
  - (320,0) → BORDER.
  - (640,0) → 0.
- SCALE=2, IMG_X=0: screen columns 0,1,2,3 → `col_read` 0,0,1,1. Rows 478,479 → `row_read` 239.
- `enable` deasserted for 10 clk mid-frame → outputs held at reset values. On reassertion, the scan restarts at (0,0) with a fresh `frame_start`.
- HS_POL=1, CLK_DIV=2 → `vga_hs` high 192 clk per 1600 clk line. Colour is aligned to `h_active` at both edges.
